// File: rtl/psid_pkg.sv
// Shared types and width constants for the PSID entry stage and its downstream checker.
// Defaults here size the standard 4-digit, 4-bit-per-digit user ID.
package psid_pkg;

   localparam int DIGITS_DEF   = 4;
   localparam int DIGIT_W_DEF  = 4;
   localparam int DEBOUNCE_DEF = 4;
   localparam int TIMEOUT_DEF  = 1000000;
   localparam int PSID_W       = DIGITS_DEF * DIGIT_W_DEF;
   localparam int DIGIT_CNT_W  = $clog2(DIGITS_DEF + 1);

   // Counter width for a terminal count of n; a 1-cycle count still needs one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PRESENT = 2'd2
   } state_t;

   typedef struct packed {
      state_t state;
      logic   btn_db;
   } dbg_t;

endpackage

// File: rtl/psid_entry_collector_btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for an asynchronous push button.
// press is a registered one-cycle pulse on each debounced 0->1 transition.
module btn_debounce
   import psid_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
)(
   input  logic clk,
   input  logic reset,
   input  logic btn_async,
   output logic btn_db,
   output logic press
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_db;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_db    <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= btn_async;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         // Any sample agreeing with the debounced level restarts the stability count.
         if (r_sync2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_db    <= r_sync2;
            r_cnt   <= '0;
            r_press <= r_sync2;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign btn_db = r_db;
   assign press  = r_press;

endmodule

// File: rtl/psid_entry_collector.sv
// Builds a user ID one digit per debounced button press, MSB-first, and offers it
// to the password checker on a valid/ready handshake; abandons idle entries on timeout.
module psid_entry_collector
   import psid_pkg::*;
#(
   parameter int DIGITS          = DIGITS_DEF,
   parameter int DIGIT_W         = DIGIT_W_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter int TIMEOUT_CYCLES  = TIMEOUT_DEF
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DIGIT_W-1:0]             userInp,
   input  logic                           userBtn,
   input  logic                           clr,
   output logic [DIGITS*DIGIT_W-1:0]      psid_out,
   output logic                           psid_valid,
   input  logic                           psid_ready,
   output logic [$clog2(DIGITS+1)-1:0]    digit_cnt,
   output logic                           busy,
   output logic                           entry_timeout,
   output dbg_t                           dbg
);

   localparam int PW    = DIGITS * DIGIT_W;
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam int TMO_W = cnt_w(TIMEOUT_CYCLES);

   state_t             r_state;
   state_t             w_next;
   logic [DIGIT_W-1:0] r_inp_s1;
   logic [DIGIT_W-1:0] r_inp_s2;
   logic [PW-1:0]      r_shreg;
   logic [CNT_W-1:0]   r_cnt;
   logic [TMO_W-1:0]   r_timer;
   logic               r_tmo_pulse;
   logic               w_press;
   logic               w_btn_db;
   logic               w_capture;
   logic               w_last;
   logic               w_timeout;
   logic               w_xfer;
   logic               w_flush;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk       (clk),
      .reset     (reset),
      .btn_async (userBtn),
      .btn_db    (w_btn_db),
      .press     (w_press)
   );

   // Handshake: the ID transfers on any edge where psid_valid and psid_ready are both
   // high; psid_valid never drops and psid_out never changes before that edge.
   assign w_capture = w_press && !clr && (r_state != PRESENT);
   assign w_last    = (r_cnt == CNT_W'(DIGITS - 1));
   assign w_timeout = (r_state == COLLECT) && !w_press && !clr &&
                      (r_timer == TMO_W'(TIMEOUT_CYCLES - 1));
   assign w_xfer    = (r_state == PRESENT) && psid_ready;
   assign w_flush   = w_xfer || w_timeout || (clr && (r_state != PRESENT));

   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_capture) w_next = w_last ? PRESENT : COLLECT;
         end
         COLLECT: begin
            if (clr)                      w_next = IDLE;
            else if (w_capture && w_last) w_next = PRESENT;
            else if (w_timeout)           w_next = IDLE;
         end
         PRESENT: begin
            if (w_xfer) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy       = (r_state == COLLECT) || (r_state == PRESENT);
      psid_valid = (r_state == PRESENT);
      psid_out   = psid_valid ? r_shreg : '0;
      digit_cnt  = r_cnt;
      dbg.state  = r_state;
      dbg.btn_db = w_btn_db;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_inp_s1    <= '0;
         r_inp_s2    <= '0;
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_timer     <= '0;
         r_tmo_pulse <= 1'b0;
      end else begin
         r_inp_s1    <= userInp;
         r_inp_s2    <= r_inp_s1;
         r_tmo_pulse <= w_timeout;
         if (w_flush) begin
            r_shreg <= '0;
            r_cnt   <= '0;
         end else if (w_capture) begin
            r_shreg <= (r_shreg << DIGIT_W) | PW'(r_inp_s2);
            r_cnt   <= r_cnt + CNT_W'(1);
         end
         // Timer only runs while an entry stays in COLLECT without a new digit.
         if ((r_state == COLLECT) && (w_next == COLLECT) && !w_capture)
            r_timer <= r_timer + TMO_W'(1);
         else
            r_timer <= '0;
      end
   end

   assign entry_timeout = r_tmo_pulse;

endmodule

// File: doc/psid_entry_collector.md
Name: psid_entry_collector

Overview:
Front-end entry stage that builds a 16-bit user ID from a 4-bit switch bank and a push button, one digit per button press. It synchronises and debounces the button and shifts the digits in MSB-first. Once all digits are entered, it presents the completed ID on a valid/ready handshake to the multi-user password checker directly downstream. Includes an inactivity timeout and an operator clear.

Parameters:
DIGITS, 4, number of nibbles per ID; PSID_W = DIGITS*DIGIT_W
DIGIT_W, 4, width of userInp / one digit
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to change the debounced button level (>=1)
TIMEOUT_CYCLES, 1000000, idle cycles in COLLECT before the entry is abandoned (>=2)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low; clock clk
userInp  in  DIGIT_W  digit switches, asynchronous
userBtn  in  1  digit-enter button, asynchronous, bouncy, active-high
clr  in  1  synchronous abort of a partial entry, active-high
psid_out  out  PSID_W  assembled ID; stable while psid_valid=1
psid_valid  out  1  ID ready for the checker
psid_ready  in  1  checker accepts the ID
digit_cnt  out  clog2(DIGITS+1)  digits captured so far
busy  out  1  high in COLLECT or PRESENT
entry_timeout  out  1  one-cycle pulse when an entry is abandoned by the timeout

Behaviour:
- Reset (reset=0 at posedge), all values 0:
  - State IDLE; psid_out, psid_valid, digit_cnt, busy and entry_timeout all 0.
  - Synchroniser flops, debounced level and debounce/timeout counters cleared.
  - Reset mid-entry or mid-PRESENT discards everything; no handshake completes.
- Synchronisation:
  - userBtn passes through a 2-flop synchroniser.
  - userInp passes through a 2-flop synchroniser, sampled in parallel with userBtn.
- Debounce:
  - btn_db changes only after the synchronised button has differed from btn_db for DEBOUNCE_CYCLES consecutive cycles.
  - Any sample equal to btn_db resets the count.
  - press = one-cycle pulse on a btn_db 0->1 transition. Releases produce nothing.
  - Clean press: press is asserted at edge 2+DEBOUNCE_CYCLES after userBtn rises.
  - The digit is captured, and digit_cnt incremented, on the following edge.
- Digit capture: shreg <= {shreg[PSID_W-DIGIT_W-1:0], inp_sync}, so the first digit ends up in the MSBs.
- States:
  - IDLE: busy=0.
    - press -> capture digit, digit_cnt=1, go to COLLECT (or PRESENT if DIGITS=1).
  - COLLECT: busy=1.
    - press -> capture digit, digit_cnt+1, reload the timeout counter.
    - When the DIGITS-th digit is captured -> PRESENT.
    - Timeout counter reaches TIMEOUT_CYCLES-1 with no press -> IDLE; clear shreg and digit_cnt; pulse entry_timeout for 1 cycle.
  - PRESENT:
    - psid_valid=1; psid_out=shreg, held constant; digit_cnt=DIGITS.
    - On psid_valid&psid_ready (transfer) -> IDLE on the next edge; psid_valid=0, shreg and digit_cnt cleared.
    - psid_ready may be held high before valid; the transfer then takes 1 cycle.
- psid_out is 0 whenever psid_valid=0.
- Boundary rules:
  - clr in IDLE/COLLECT -> IDLE, counters cleared, no timeout pulse. clr ignored in PRESENT, so a valid ID is never withdrawn.
  - clr and press in the same cycle: clr wins; the digit is dropped.
  - Presses during PRESENT are ignored, not queued.
  - A press in the same cycle as a transfer is ignored.
  - Timeout and press in the same cycle: press wins and the counter reloads.
  - Timeout counter is held at 0 outside COLLECT.
  - digit_cnt never exceeds DIGITS.
- Counter widths: clog2 of the respective parameter; no wrap-around is reachable.

Decomposition:
- Package psid_pkg holds:
  - state enum {IDLE, COLLECT, PRESENT};
  - localparam PSID_W;
  - the clog2-based counter width constants shared with the checker.
- One sub-module, btn_debounce:
  - 2-flop synchroniser, debounce counter and rising-edge pulse;
  - parameter DEBOUNCE_CYCLES; ports clk, reset, btn_async, btn_db, press.
  - Reusable for other operator buttons.
- The FSM, shift register, userInp synchroniser and timeout counter stay in the top module.

Test Plan:
- Digits and handshake (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64, psid_ready=0): clean presses with userInp=1,2,3,4 -> digit_cnt steps 1..4; psid_valid=1, psid_out=16'h1234. Hold psid_ready=0 for 10 cycles, then 1 for one cycle -> valid and ID stable until the transfer; next cycle psid_valid=0, psid_out=0, digit_cnt=0, busy=0.
- Bounce rejection: 2-cycle userBtn pulses ×3, then a stable press with userInp=4'hA -> exactly one digit captured, digit_cnt=1, captured on edge 7 after the stable rise.
- Timeout: 2 digits entered, then idle 64 cycles -> single-cycle entry_timeout, state IDLE, digit_cnt=0, psid_valid never asserted. Next 4 digits 9,8,7,6 -> psid_out=16'h9876.
- Clear and ignored presses: clr after 3 digits -> digit_cnt=0, no timeout pulse. Press in PRESENT with ID 16'h5555 and userInp=4'hF -> psid_out stays 16'h5555. clr asserted in PRESENT -> psid_valid stays 1.
- Reset mid-PRESENT (ID 16'hBEEF, psid_ready=1 and reset=0 in the same cycle): outputs all 0 next cycle, no transfer counted. psid_ready held high before the 4th digit -> valid asserted for exactly 1 cycle.
